// File: rtl/serv_sleep_ctrl.sv
// serv_sleep_ctrl: WFI power-state controller that drains the buses, gates the core and then settles it on wakeup.
// Define SERV_SLEEP_STATS_EN to build the o_sleep_cycles counter; otherwise that port is tied to zero.
module serv_sleep_ctrl #(
   parameter int unsigned WAKE_DELAY = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_sleep_req,
   input  logic        i_wakeup_req,
   input  logic        i_ibus_busy,
   input  logic        i_dbus_busy,
   output logic        o_core_en,
   output logic        o_sleeping,
   output logic        o_wake_ack,
   output logic [31:0] o_sleep_cycles
);
   typedef enum logic [1:0] {RUN, DRAIN, SLEEP, WAKE} state_t;
   localparam logic [7:0] DELAY = 8'(WAKE_DELAY);
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       wake_ack_q, wake_ack_d;
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wake_ack_d = 1'b0;
      case (state_q)
         // a WFI with a wakeup already pending retires as a NOP; suppressing back-to-back acks
         RUN:   if (i_sleep_req && i_wakeup_req) wake_ack_d = ~wake_ack_q;
                else if (i_sleep_req) state_d = DRAIN;
         DRAIN: if (!(i_ibus_busy || i_dbus_busy)) begin
                   state_d = i_wakeup_req ? WAKE : SLEEP;
                   cnt_d   = i_wakeup_req ? DELAY : cnt_q;
                end
         SLEEP: if (i_wakeup_req) begin
                   state_d = WAKE;
                   cnt_d   = DELAY;
                end
         WAKE:  if (cnt_q == 8'd0) begin
                   state_d    = RUN;
                   wake_ack_d = 1'b1;
                end else cnt_d = cnt_q - 8'd1;
         default: state_d = RUN;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= RUN;
         cnt_q      <= 8'd0;
         wake_ack_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wake_ack_q <= wake_ack_d;
      end
   end
   assign o_core_en  = (state_q == RUN);
   assign o_sleeping = (state_q == SLEEP);
   assign o_wake_ack = wake_ack_q;
`ifdef SERV_SLEEP_STATS_EN
   logic [31:0] sleep_cycles_q;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) sleep_cycles_q <= 32'd0;
      else if (state_q == SLEEP) sleep_cycles_q <= sleep_cycles_q + 32'd1;
   end
   assign o_sleep_cycles = sleep_cycles_q;
`else
   assign o_sleep_cycles = 32'h0;
`endif
endmodule

// File: tb/tb_serv_sleep_ctrl.sv
// tb_serv_sleep_ctrl: three instances (WAKE_DELAY 4, 0, 3) checked against directed timelines and a cycle model.
module tb_serv_sleep_ctrl;
   logic clk = 1'b0, rst_n = 1'b0, s = 1'b0, w = 1'b0, ib = 1'b0, db = 1'b0;
   logic [2:0] ce, sl, ak;
   logic [31:0] sc0, sc1, sc2;
   int n_checks = 0, n_fail = 0;
   // model: mode 0 run, 1 drain, 2 sleep, 3 wake; left = remaining WAKE cycles
   int D[3] = '{4, 0, 3};
   int m_mode[3] = '{0, 0, 0};
   int m_left[3] = '{0, 0, 0};
   logic m_ack[3] = '{1'b0, 1'b0, 1'b0};
   logic [31:0] m_slp[3] = '{32'd0, 32'd0, 32'd0};

   serv_sleep_ctrl #(.WAKE_DELAY(4)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .i_sleep_req(s), .i_wakeup_req(w),
      .i_ibus_busy(ib), .i_dbus_busy(db), .o_core_en(ce[0]), .o_sleeping(sl[0]), .o_wake_ack(ak[0]), .o_sleep_cycles(sc0));
   serv_sleep_ctrl #(.WAKE_DELAY(0)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .i_sleep_req(s), .i_wakeup_req(w),
      .i_ibus_busy(ib), .i_dbus_busy(db), .o_core_en(ce[1]), .o_sleeping(sl[1]), .o_wake_ack(ak[1]), .o_sleep_cycles(sc1));
   serv_sleep_ctrl #(.WAKE_DELAY(3)) dut2 (.i_clk(clk), .i_rst_n(rst_n), .i_sleep_req(s), .i_wakeup_req(w),
      .i_ibus_busy(ib), .i_dbus_busy(db), .o_core_en(ce[2]), .o_sleeping(sl[2]), .o_wake_ack(ak[2]), .o_sleep_cycles(sc2));

   always #5 clk = ~clk;

   function automatic logic [2:0] obs(input int k);
      return {ce[k], sl[k], ak[k]};
   endfunction
   function automatic logic [31:0] obs_sc(input int k);
      return k == 0 ? sc0 : k == 1 ? sc1 : sc2;
   endfunction
   function automatic logic [2:0] expm(input int k);
      return {m_mode[k] == 0, m_mode[k] == 2, m_ack[k]};
   endfunction
   function automatic logic [31:0] exp_sc(input int k);
`ifdef SERV_SLEEP_STATS_EN
      return m_slp[k];
`else
      return 32'd0;
`endif
   endfunction

   task automatic tick;
      int nm[3], nl[3];
      logic na[3];
      logic [31:0] ns[3];
      for (int k = 0; k < 3; k++) begin
         nm[k] = m_mode[k]; nl[k] = m_left[k]; na[k] = 1'b0; ns[k] = m_slp[k];
         if (!rst_n) begin
            nm[k] = 0; nl[k] = 0; ns[k] = 32'd0;
         end else case (m_mode[k])
            0: if (s && w) na[k] = !m_ack[k];
               else if (s) nm[k] = 1;
            1: if (!(ib || db)) begin
                  nm[k] = w ? 3 : 2;
                  nl[k] = D[k] + 1;
               end
            2: begin
                  ns[k] = m_slp[k] + 32'd1;
                  if (w) begin nm[k] = 3; nl[k] = D[k] + 1; end
               end
            default: begin
                  nl[k] = m_left[k] - 1;
                  if (nl[k] == 0) begin nm[k] = 0; na[k] = 1'b1; end
               end
         endcase
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         m_mode[k] = nm[k]; m_left[k] = nl[k]; m_ack[k] = na[k]; m_slp[k] = ns[k];
      end
   endtask

   task automatic idle;
      s = 1'b0; w = 1'b0; ib = 1'b0; db = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s = 1'($urandom); w = 1'($urandom); ib = 1'($urandom); db = 1'($urandom);
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (obs(k) !== 3'b100 || obs_sc(k) !== 32'd0) begin
            n_fail++;
            $display("FAIL reset inst%0d: got en/slp/ack=%b cycles=%0d, expected 100 and 0", k, obs(k), obs_sc(k));
         end
      end
      idle();
   endtask

   task automatic test_idle_sleep;
      logic [2:0] e;
      for (int t = 0; t < 10; t++) tick();
      for (int t = 10; t <= 25; t++) begin
         s = (t == 10); w = (t == 20);
         tick();
         e = (t + 1 == 11) ? 3'b000 : (t + 1 <= 20) ? 3'b010 : (t + 1 <= 25) ? 3'b000 : 3'b101;
         n_checks++;
         if (obs(0) !== e) begin
            n_fail++;
            $display("FAIL idle_sleep cycle %0d: got en/slp/ack=%b expected %b", t + 1, obs(0), e);
         end
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs(k) !== expm(k)) begin
               n_fail++;
               $display("FAIL idle_sleep model inst%0d cycle %0d: got %b expected %b", k, t + 1, obs(k), expm(k));
            end
         end
      end
      n_checks++;
`ifdef SERV_SLEEP_STATS_EN
      if (sc0 !== 32'd9) begin
`else
      if (sc0 !== 32'd0) begin
`endif
         n_fail++;
         $display("FAIL idle_sleep sleep_cycles: got %0d", sc0);
      end
      idle();
   endtask

   task automatic test_collision;
      tick();
      s = 1'b1; w = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (obs(k) !== 3'b101) begin
            n_fail++;
            $display("FAIL collision inst%0d: got en/slp/ack=%b expected 101", k, obs(k));
         end
      end
      idle();
      tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (obs(k) !== 3'b100) begin
            n_fail++;
            $display("FAIL collision_after inst%0d: got en/slp/ack=%b expected 100", k, obs(k));
         end
      end
   endtask

   task automatic test_busy_drain;
      logic [2:0] e;
      for (int t = 0; t <= 10; t++) begin
         s = (t == 0); ib = (t <= 4); w = (t >= 2 && t <= 6);
         tick();
         e = (t + 1 <= 10) ? 3'b000 : 3'b101;
         n_checks++;
         if (obs(0) !== e) begin
            n_fail++;
            $display("FAIL busy_drain cycle %0d: got en/slp/ack=%b expected %b", t + 1, obs(0), e);
         end
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs(k) !== expm(k)) begin
               n_fail++;
               $display("FAIL busy_drain model inst%0d cycle %0d: got %b expected %b", k, t + 1, obs(k), expm(k));
            end
         end
      end
      idle();
   endtask

   task automatic test_wake_delay;
      logic [2:0] e1, e2;
      tick();
      for (int t = 0; t <= 9; t++) begin
         s = (t == 0); w = (t == 3 || t == 4);
         tick();
         e1 = (t + 1 == 1) ? 3'b000 : (t + 1 <= 3) ? 3'b010 : (t + 1 == 4) ? 3'b000 : (t + 1 == 5) ? 3'b101 : 3'b100;
         e2 = (t + 1 == 1) ? 3'b000 : (t + 1 <= 3) ? 3'b010 : (t + 1 <= 7) ? 3'b000 : (t + 1 == 8) ? 3'b101 : 3'b100;
         n_checks++;
         if (obs(1) !== e1 || obs(2) !== e2) begin
            n_fail++;
            $display("FAIL wake_delay cycle %0d: got d0=%b d3=%b expected d0=%b d3=%b", t + 1, obs(1), obs(2), e1, e2);
         end
      end
      idle();
   endtask

   task automatic test_reset_mid_sleep;
      tick();
      s = 1'b1;
      tick();
      s = 1'b0;
`ifdef SERV_SLEEP_STATS_EN
      force dut0.sleep_cycles_q = 32'hFFFF_FFFE;
      #1;
      release dut0.sleep_cycles_q;
      m_slp[0] = 32'hFFFF_FFFE;
`endif
      for (int i = 0; i < 4; i++) tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (obs(k) !== 3'b010) begin
            n_fail++;
            $display("FAIL mid_sleep inst%0d: got en/slp/ack=%b expected 010", k, obs(k));
         end
      end
`ifdef SERV_SLEEP_STATS_EN
      n_checks++;
      if (sc0 !== 32'd1) begin
         n_fail++;
         $display("FAIL wrap: got sleep_cycles=%0d expected 1", sc0);
      end
`endif
      rst_n = 1'b0; w = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (obs(k) !== 3'b100 || obs_sc(k) !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_sleep inst%0d: got en/slp/ack=%b cycles=%0d expected 100 and 0", k, obs(k), obs_sc(k));
         end
      end
      idle();
   endtask

   task automatic test_random;
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         s = ($urandom_range(0, 3) == 0); w = ($urandom_range(0, 3) == 0);
         ib = ($urandom_range(0, 2) == 0); db = ($urandom_range(0, 2) == 0);
         tick();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs(k) !== expm(k) || obs_sc(k) !== exp_sc(k)) begin
               n_fail++;
               $display("FAIL random inst%0d step %0d: got %b/%0d expected %b/%0d", k, i, obs(k), obs_sc(k), expm(k), exp_sc(k));
            end
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_idle_sleep();
      test_collision();
      test_busy_drain();
      test_wake_delay();
      test_reset_mid_sleep();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/serv_sleep_ctrl.md
# serv_sleep_ctrl

Power-state controller directly downstream of the WFI sleep/wakeup request logic. Consumes the sleep and wakeup requests, drains outstanding bus transactions, then gates the core via a clock-enable. On wakeup it holds the core off for a programmable settling delay before resuming. Sits between the request logic and the core clock-gating cell.

## Interface
Parameters:
- WAKE_DELAY, 4: extra settling cycles in WAKE before the core is re-enabled; range 0..255.

Ports:
- i_clk  in  1  sole clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_sleep_req  in  1  WFI sleep request; level, sampled each cycle.
- i_wakeup_req  in  1  enabled interrupt pending; level.
- i_ibus_busy  in  1  instruction fetch outstanding (cyc high, ack not yet seen).
- i_dbus_busy  in  1  data access outstanding.
- o_core_en  out  1  core clock-enable; 1 = core runs.
- o_sleeping  out  1  high while in SLEEP.
- o_wake_ack  out  1  one-cycle pulse when a WFI completes (core resumes).
- o_sleep_cycles  out  32  cycles spent in SLEEP (see Configuration).

## Operation
- Four-state FSM: RUN, DRAIN, SLEEP, WAKE. 8-bit delay counter `cnt`.
- o_core_en = (state == RUN). o_sleeping = (state == SLEEP). Both are decoded from the state register only, with no input-to-output combinational path.
- RUN:
  - i_sleep_req & i_wakeup_req → stay in RUN, pulse o_wake_ack. The WFI retires as a NOP.
  - i_sleep_req & ~i_wakeup_req → DRAIN.
- DRAIN:
  - Stay while i_ibus_busy | i_dbus_busy, regardless of wakeup.
  - Once both busy inputs are low: i_wakeup_req → WAKE; otherwise → SLEEP.
  - Entering WAKE loads cnt = WAKE_DELAY.
- SLEEP:
  - i_wakeup_req → WAKE, with cnt = WAKE_DELAY.
  - i_sleep_req is ignored.
- WAKE:
  - cnt == 0 → RUN, and o_wake_ack is registered high for the first RUN cycle.
  - Otherwise cnt decrements.
  - Wakeup deasserting during WAKE is ignored; the wake is committed.
- o_wake_ack is high for exactly one cycle per completed WFI and never in two consecutive cycles.
- Reset overrides everything, including mid-DRAIN, mid-SLEEP and mid-WAKE.

## Timing
- Reset values: state RUN, o_core_en 1, o_sleeping 0, o_wake_ack 0, cnt 0, o_sleep_cycles 0.
- Sleep entry:
  - i_sleep_req sampled at edge N → DRAIN from N+1.
  - o_core_en is low in the cycle after N.
  - The core therefore executes the i_sleep_req cycle itself and no more.
- Drain: leaves DRAIN at the first edge where both busy inputs are low. With idle buses, DRAIN lasts exactly 1 cycle.
- Wake latency, counted from wakeup sampled in SLEEP to o_core_en high: WAKE_DELAY+1 cycles in WAKE, then RUN. With WAKE_DELAY = 0 this is 1 WAKE cycle.
- Sleep/wakeup collision in RUN: o_wake_ack goes high the next cycle; o_core_en never drops.
- Wakeup arriving during a busy DRAIN: the transition is deferred until the buses are idle, then goes straight to WAKE. SLEEP is never entered, so o_sleeping stays 0.

## Configuration
- Macro SERV_SLEEP_STATS_EN.
- Defined: o_sleep_cycles is a 32-bit counter.
  - Increments once per cycle in SLEEP.
  - Wraps from 0xFFFFFFFF to 0.
  - Holds its value in the other states.
  - Cleared only by reset.
- Undefined: no counter is built; the port remains and is tied to 32'h0.
- FSM behaviour is identical in both builds.

## Test plan
- Reset: hold i_rst_n = 0 for 2 cycles with random inputs → o_core_en = 1, o_sleeping = 0, o_wake_ack = 0, o_sleep_cycles = 0.
- Idle sleep/wake, WAKE_DELAY = 4: sleep_req pulse at cycle 10, buses idle, wakeup at cycle 20 → DRAIN at 11, SLEEP at 12–20, WAKE at 21–25, o_core_en and o_wake_ack high at 26. With the macro defined, o_sleep_cycles = 9.
- Collision: sleep_req and wakeup_req both high in one RUN cycle → o_core_en stays 1, single o_wake_ack pulse the next cycle, o_sleeping never asserts.
- Busy drain: i_ibus_busy high for 5 cycles after the sleep request, wakeup asserted on the 2nd of those cycles → DRAIN for 5 cycles, then WAKE directly, o_sleeping stays 0.
- WAKE_DELAY = 0 and wakeup dropping mid-WAKE (use WAKE_DELAY = 3, drop after 1 cycle) → 1 WAKE cycle and 4 WAKE cycles respectively, each followed by RUN with an o_wake_ack pulse.
- Reset mid-SLEEP, and wrap: reset asserted in SLEEP → RUN next cycle. With the macro defined and the counter forced to 0xFFFFFFFE, 3 SLEEP cycles → o_sleep_cycles = 1.
